// File: rtl/avalon_packetizer_if.sv
// Avalon-ST stream bundle shared by the raw (unframed) and framed sides of the packetizer.
interface avalon_st_if #(
  parameter int DATA_WIDTH_IN_BYTES = 16
);
  localparam int EW = (DATA_WIDTH_IN_BYTES > 1) ? $clog2(DATA_WIDTH_IN_BYTES) : 1;

  logic [8*DATA_WIDTH_IN_BYTES-1:0] data;
  logic                             valid;
  logic                             rdy;
  logic                             sop;
  logic                             eop;
  logic [EW-1:0]                    empty;

  modport master (output data, valid, sop, eop, empty, input rdy);
  modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/avalon_packetizer.sv
// Frames an unframed word stream into Avalon-ST packets of cfg_pkt_len bytes,
// through a single output register with full-throughput backpressure.
module avalon_packetizer #(
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int MAX_LEN_BYTES       = 65535
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  raw_msg,
  avalon_st_if.master framed_msg,
  input  logic [15:0] cfg_pkt_len,
  output logic        len_error,
  output logic [15:0] packets_sent,
  output logic        busy
);
  localparam int LG = $clog2(DATA_WIDTH_IN_BYTES);

  typedef enum logic {IDLE, IN_PACKET} state_t;

  state_t      state, state_nxt;
  logic [15:0] len_q;
  logic [15:0] word_cnt;
  logic [15:0] cur_len;
  logic [15:0] cur_idx;
  logic [16:0] cur_words;
  logic [LG-1:0] cur_empty;
  logic        first_word;
  logic        last_word;
  logic        raw_rdy;
  logic        accept;

  // The first word of a packet uses the live cfg_pkt_len; later words use the latched copy.
  always_comb begin
    first_word = (state == IDLE);
    cur_len    = first_word ? cfg_pkt_len : len_q;
    cur_idx    = first_word ? '0 : word_cnt;
    cur_words  = ({1'b0, cur_len} + 17'(DATA_WIDTH_IN_BYTES - 1)) >> LG;
    last_word  = (({1'b0, cur_idx} + 17'd1) == cur_words);
    cur_empty  = LG'((cur_words << LG) - {1'b0, cur_len});
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    len_error = first_word &&
                ((cfg_pkt_len == '0) || ({1'b0, cfg_pkt_len} > 17'(MAX_LEN_BYTES)));
    raw_rdy   = (~framed_msg.valid | framed_msg.rdy) & ~len_error;
    accept    = raw_msg.valid & raw_rdy;
    busy      = (state == IN_PACKET);
    case (state)
      IDLE:      if (accept && !last_word) state_nxt = IN_PACKET;
      IN_PACKET: if (accept && last_word)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign raw_msg.rdy = raw_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      framed_msg.valid <= 1'b0;
      framed_msg.data  <= '0;
      framed_msg.sop   <= 1'b0;
      framed_msg.eop   <= 1'b0;
      framed_msg.empty <= '0;
      len_q            <= '0;
      word_cnt         <= '0;
    end else if (accept) begin
      framed_msg.valid <= 1'b1;
      framed_msg.data  <= raw_msg.data;
      framed_msg.sop   <= first_word;
      framed_msg.eop   <= last_word;
      framed_msg.empty <= last_word ? cur_empty : '0;
      word_cnt         <= cur_idx + 16'd1;
      if (first_word) len_q <= cfg_pkt_len;
    end else if (framed_msg.rdy) begin
      framed_msg.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      packets_sent <= '0;
    else if (framed_msg.valid && framed_msg.rdy && framed_msg.eop)
      packets_sent <= packets_sent + 16'd1;
  end
endmodule
